// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that computes {cout,sum} = a + b + cin
// using one 1-bit full-adder cell per cycle with a registered carry.
//
// Handshake: an operand transfer happens at a rising edge where
// in_valid & in_ready are both 1. in_ready is high only in IDLE. A result
// transfer happens at a rising edge where out_valid & out_ready are both 1.
// out_valid is high only in DONE. sum/cout hold stable until that edge.
// in_valid is ignored outside IDLE.
//
// Optional feature: define SERIAL_ADD_OVF_EN to add the registered
// two's-complement overflow output ovf.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_sum;
  logic fa_cout;
  logic last_bit;

  // The single full-adder cell working on the current LSBs and the carry.
  always_comb begin
    fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    fa_cout  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          // carry_q here is the carry into the MSB position.
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Outputs come straight from registers or a decode of the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = res_q;
    cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed checks of serial_add_ctrl
// against an arithmetic reference model. Define SERIAL_ADD_OVF_EN to also
// check the overflow output.
module tb_serial_add_ctrl;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W+1:0] exp_q[$];   // {ovf, cout, sum}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer addition, overflow from operand/result signs.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    longint unsigned total;
    logic [W-1:0]    s;
    logic            co;
    logic            ov;
    total = longint'(x) + longint'(y) + longint'(c);
    s     = W'(total % (64'd1 << W));
    co    = (total >= (64'd1 << W));
    ov    = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
    return {ov, co, s};
  endfunction

  task automatic check_result(input string tag, input logic [W+1:0] e);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, sum, e[W-1:0]);
    check({tag, "_cout"}, cout, e[W]);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, ovf, e[W+1]);
`endif
  endtask

  // ---------------- driver ----------------
  // One full operation: accept, watch RUN, hold DONE for 'hold' cycles,
  // then acknowledge. 'junk' keeps in_valid high with garbage after accept.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                       input int hold, input bit junk);
    logic [W+1:0] e;
    int lat;
    check("idle_in_ready", in_ready, 1);
    check("idle_out_valid", out_valid, 0);
    a = oa; b = ob; cin = oc; in_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(ref_add(oa, ob, oc));
    if (junk) begin
      a = 8'h55; b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      check("run_in_ready", in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, W);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      check_result("done_hold", e);
      check("done_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    check_result("done", e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    // If the ack edge had also accepted operands, in_ready would now be 0.
    check("ack_out_valid", out_valid, 0);
    check("ack_in_ready", in_ready, 1);
  endtask

  // Reset in the middle of RUN: result must be dropped, no out_valid later.
  task automatic reset_mid_run();
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_out_valid", out_valid, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1);
    for (int i = 0; i < W + 3; i++) begin
      check("post_rst_no_valid", out_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #2 rst = 1'b1;
    #2;
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_out_valid", out_valid, 0);
`ifdef SERIAL_ADD_OVF_EN
    check("reset_ovf", ovf, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", in_ready, 1);

    // Directed corner cases.
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);   // carry out of every bit
    do_op(8'h00, 8'h00, 1'b1, 0, 1'b0);   // carry-in only
    do_op(8'h7F, 8'h01, 1'b0, 1, 1'b0);   // signed overflow
    do_op(8'hFF, 8'hFF, 1'b1, 5, 1'b0);   // max sum, long stall in DONE
    do_op(8'h12, 8'h34, 1'b0, 2, 1'b1);   // in_valid noise during RUN/DONE
    do_op(8'h80, 8'h80, 1'b0, 0, 1'b0);   // negative overflow, wrap to 0

    reset_mid_run();
    do_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..64).
REQ-002 The block SHALL have the following ports, one per line, clock and reset first:
  clk        input   1      single clock, rising-edge active
  rst        input   1      asynchronous, active-high reset
  in_valid   input   1      operand request valid
  in_ready   output  1      block can accept operands
  a          input   WIDTH  operand A
  b          input   WIDTH  operand B
  cin        input   1      carry-in
  out_valid  output  1      result valid
  out_ready  input   1      consumer accepts result
  sum        output  WIDTH  result sum
  cout       output  1      result carry-out
REQ-003 The block SHALL have one clock, clk, and one reset, rst; rst SHALL be asynchronous and active-high.

Function
REQ-004 The block SHALL compute {cout,sum} = a + b + cin bit-serially, using exactly one 1-bit full-adder cell per cycle with a registered carry.
REQ-005 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-006 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-007 In IDLE, a transfer (in_valid & in_ready) at a rising edge SHALL perform these actions: capture a, b and cin into shift and carry registers; clear the bit counter; move to RUN.
REQ-008 Each RUN cycle SHALL add the LSBs of the A and B shift registers plus the carry register; shift the sum bit into the result MSB; shift A and B right by one; update the carry; increment the counter.
REQ-009 RUN SHALL last exactly WIDTH cycles, then move to DONE; out_valid SHALL rise WIDTH edges after the accept edge.
REQ-010 In DONE, sum and cout SHALL hold stable until out_ready is 1 at a rising edge; the FSM SHALL then move to IDLE.
REQ-011 in_valid outside IDLE SHALL be ignored; no operands SHALL be captured and no state SHALL change.
REQ-012 A new accept SHALL NOT occur on the same edge as a DONE->IDLE transition; the minimum issue interval SHALL be WIDTH+2 cycles.
REQ-013 Carry-out SHALL be the final carry after bit WIDTH-1; sum SHALL wrap modulo 2^WIDTH.
REQ-014 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap within a RUN.
REQ-015 in_ready, out_valid, sum and cout SHALL be driven from registers, with no combinational input-to-output paths.

Reset
REQ-016 Asserting rst SHALL immediately force state=IDLE, sum=0, cout=0, out_valid=0, carry and counter to 0, and shift registers to 0.
REQ-017 in_ready SHALL read 1 on the first rising edge after rst deasserts.
REQ-018 rst asserted during RUN or DONE SHALL abort the operation and discard the result; no out_valid pulse SHALL follow.

Configuration
REQ-019 Macro SERIAL_ADD_OVF_EN defined: the block SHALL add output port ovf (1 bit), the two's-complement overflow, equal to (carry into bit WIDTH-1) XOR cout.
REQ-020 With SERIAL_ADD_OVF_EN defined, ovf SHALL be registered, SHALL be valid with out_valid, SHALL hold in DONE and SHALL reset to 0.
REQ-021 Macro SERIAL_ADD_OVF_EN undefined: the ovf port and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-022 WIDTH=8, a=0xFF, b=0x01, cin=0, out_ready=1 -> out_valid rises 8 edges after accept; sum=0x00, cout=1.
REQ-023 WIDTH=8, a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0; a=0x7F, b=0x01, cin=0 with SERIAL_ADD_OVF_EN -> sum=0x80, ovf=1, cout=0.
REQ-024 out_ready held 0 for 5 cycles in DONE -> sum, cout and out_valid stable for all 5 cycles; IDLE one edge after out_ready=1.
REQ-025 in_valid=1 with a=0x55 during RUN of 0x12+0x34 -> result 0x46 unaffected; 0x55 not captured; in_ready=0 throughout.
REQ-026 rst pulsed at RUN cycle 4 -> all outputs 0 immediately; no out_valid; in_ready=1 after release; the next operation 0x0F+0x01 gives 0x10.
